// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Program store (2**ADDR_W x INSTR_W) plus instruction register.
//               The store is loaded while idle. In RUN the block steps through
//               a three-cycle instruction slot (phase 0,1,2). At the end of
//               each phase-0 cycle it captures mem[PC] into `literal`. It
//               stops for good when a HALT opcode is captured.
// Ports       :
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   load_en      in   program write strobe, honoured in IDLE only
//   load_addr    in   program write address
//   load_data    in   program write data
//   run          in   level, starts execution from IDLE
//   PC           in   current program counter from the PC stage
//   literal      out  instruction register
//   phase        out  slot phase 0/1/2
//   instr_valid  out  literal holds a fetched instruction (phases 1 and 2)
//   halted       out  HALT opcode has been fetched
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int         ADDR_W  = 6,
    parameter int         INSTR_W = 49,
    parameter logic [4:0] HALT_OP = 5'h1F
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               run,
    input  logic [ADDR_W-1:0]  PC,
    output logic [INSTR_W-1:0] literal,
    output logic [1:0]         phase,
    output logic               instr_valid,
    output logic               halted
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Program store. It has no reset, so its contents survive rst_n.
    // ------------------------------------------------------------------
    logic [INSTR_W-1:0] mem [0:c_DEPTH-1];

    state_t             state_q, state_d;
    logic [1:0]         phase_q, phase_d;
    logic [INSTR_W-1:0] literal_q, literal_d;
    logic               valid_q, valid_d;
    logic               halted_q, halted_d;
    logic               mem_we;

    logic [INSTR_W-1:0] w_fetch_word;
    logic [4:0]         w_fetch_op;
    logic               w_fetch_is_halt;

    // The store read is only ever used as the D input of literal_q.
    // PC therefore reaches the outputs one clock later, never combinationally.
    assign w_fetch_word    = mem[PC];
    assign w_fetch_op      = w_fetch_word[INSTR_W-1 -: 5];
    assign w_fetch_is_halt = (w_fetch_op == HALT_OP);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[load_addr] <= load_data;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            phase_q   <= 2'd0;
            literal_q <= '0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            literal_q <= literal_d;
            valid_q   <= valid_d;
            halted_q  <= halted_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        literal_d = literal_q;
        valid_d   = valid_q;
        halted_d  = halted_q;
        mem_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // In IDLE a write and run in the same cycle are both honoured.
                // The first capture happens a full cycle later, so it sees
                // the new word.
                mem_we    = load_en;
                literal_d = '0;
                valid_d   = 1'b0;
                halted_d  = 1'b0;
                phase_d   = 2'd0;
                if (run) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                case (phase_q)
                    2'd0: begin
                        phase_d   = 2'd1;
                        literal_d = w_fetch_word;
                        if (w_fetch_is_halt) begin
                            // Phase stays frozen at 1 with the HALT word on
                            // literal, but that word is never flagged valid.
                            state_d  = S_HALTED;
                            halted_d = 1'b1;
                            valid_d  = 1'b0;
                        end else begin
                            valid_d  = 1'b1;
                        end
                    end
                    2'd1: begin
                        phase_d = 2'd2;
                    end
                    2'd2: begin
                        // The PC stage updates PC on this same edge. The next
                        // phase-0 cycle therefore sees the new PC as stable.
                        phase_d = 2'd0;
                        valid_d = 1'b0;
                    end
                    default: begin
                        phase_d = 2'd0;
                        valid_d = 1'b0;
                    end
                endcase
            end

            S_HALTED: begin
                // Terminal. Only rst_n leaves this state. run and load_en
                // have no effect here.
                phase_d  = 2'd1;
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end

            default: begin
                state_d   = S_IDLE;
                phase_d   = 2'd0;
                literal_d = '0;
                valid_d   = 1'b0;
                halted_d  = 1'b0;
            end
        endcase
    end

    assign literal     = literal_q;
    assign phase       = phase_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed bench for instr_fetch. Expected instruction words
//               go into a queue when a slot starts. Each capture (the first
//               cycle with phase 1 and instr_valid) pops one entry and
//               compares it with literal. A small PC-stage model provides
//               sequential and branch PC updates.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam int ADDR_W  = 6;
    localparam int INSTR_W = 49;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               load_en = 1'b0;
    logic [ADDR_W-1:0]  load_addr = '0;
    logic [INSTR_W-1:0] load_data = '0;
    logic               run = 1'b0;
    logic [ADDR_W-1:0]  PC;
    logic [INSTR_W-1:0] literal;
    logic [1:0]         phase;
    logic               instr_valid;
    logic               halted;

    logic [ADDR_W-1:0]  pc_drv = '0;
    logic [ADDR_W-1:0]  pc_init = '0;
    logic [ADDR_W-1:0]  pc_m;
    logic               pc_model_en = 1'b0;

    int                 checks = 0;
    int                 errors = 0;
    logic [INSTR_W-1:0] sb_q [$];

    localparam logic [INSTR_W-1:0] W_AA   = 49'h0_0000_0000_00AA;
    localparam logic [INSTR_W-1:0] W_BB   = 49'h0_0000_0000_00BB;
    localparam logic [INSTR_W-1:0] W_BRA  = {5'h12, 38'd0, 6'd5};
    localparam logic [INSTR_W-1:0] W_HALT = {5'h1F, 44'd0};

    instr_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .run         (run),
        .PC          (PC),
        .literal     (literal),
        .phase       (phase),
        .instr_valid (instr_valid),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // PC stage model. At the end of phase 2 it jumps to the target of a
    // BRA (opcode 5'h12), otherwise it increments.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc_m <= pc_init;
        else if (phase == 2'd2)
            pc_m <= (literal[INSTR_W-1 -: 5] == 5'h12) ? literal[ADDR_W-1:0] : pc_m + 6'd1;
    end

    assign PC = pc_model_en ? pc_m : pc_drv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock. Runs the scoreboard on each new capture.
    task automatic step();
        logic [INSTR_W-1:0] e;
        @(posedge clk);
        @(negedge clk);
        if (rst_n === 1'b1 && instr_valid === 1'b1 && phase === 2'd1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_unexpected: observed capture %0h expected none", literal);
            end else begin
                e = sb_q.pop_front();
                chk("sb_literal", {15'd0, literal}, {15'd0, e});
            end
        end
    endtask

    task automatic do_reset(input logic [ADDR_W-1:0] start, input logic model);
        @(negedge clk);
        rst_n       = 1'b0;
        run         = 1'b0;
        load_en     = 1'b0;
        pc_init     = start;
        pc_drv      = start;
        pc_model_en = model;
        #1;
        chk("rst_literal", {15'd0, literal}, 64'd0);
        chk("rst_phase",   {62'd0, phase},   64'd0);
        chk("rst_valid",   {63'd0, instr_valid}, 64'd0);
        chk("rst_halted",  {63'd0, halted},  64'd0);
        chk("sb_drain",    64'(sb_q.size()), 64'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_word(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    initial begin
        // ---------------- load / start / capture ----------------
        do_reset(6'd0, 1'b0);
        load_word(6'd0, W_AA);
        load_word(6'd1, W_BB);
        run = 1'b1;
        step();
        chk("t1_phase0", {62'd0, phase}, 64'd0);
        chk("t1_valid0", {63'd0, instr_valid}, 64'd0);
        run = 1'b0;
        sb_q.push_back(W_AA);
        step();
        chk("t1_phase1", {62'd0, phase}, 64'd1);
        chk("t1_valid1", {63'd0, instr_valid}, 64'd1);
        step();
        chk("t1_phase2", {62'd0, phase}, 64'd2);
        chk("t1_valid2", {63'd0, instr_valid}, 64'd1);
        chk("t1_lit2", {15'd0, literal}, {15'd0, W_AA});
        pc_drv = 6'd1;
        step();
        chk("t1_phase0b", {62'd0, phase}, 64'd0);
        chk("t1_valid0b", {63'd0, instr_valid}, 64'd0);
        sb_q.push_back(W_BB);
        step();
        chk("t1_phase1b", {62'd0, phase}, 64'd1);

        // ---------------- branch alignment ----------------
        do_reset(6'd0, 1'b1);
        load_word(6'd0, W_BRA);
        load_word(6'd5, 49'h123);
        run = 1'b1;
        step();
        run = 1'b0;
        sb_q.push_back(W_BRA);
        step();
        step();
        step();
        chk("t2_pc_after_bra", {58'd0, PC}, 64'd5);
        sb_q.push_back(49'h123);
        step();
        chk("t2_lit_target", {15'd0, literal}, 64'h123);

        // ---------------- HALT ----------------
        do_reset(6'd0, 1'b1);
        load_word(6'd0, 49'h10);
        load_word(6'd1, 49'h11);
        load_word(6'd2, W_HALT);
        load_word(6'd3, 49'h33);
        run = 1'b1;
        step();
        run = 1'b0;
        sb_q.push_back(49'h10);
        step();
        step();
        step();
        sb_q.push_back(49'h11);
        step();
        step();
        step();
        chk("t3_pc2", {58'd0, PC}, 64'd2);
        step();
        chk("t3_halted", {63'd0, halted}, 64'd1);
        chk("t3_valid", {63'd0, instr_valid}, 64'd0);
        chk("t3_phase", {62'd0, phase}, 64'd1);
        chk("t3_lit", {15'd0, literal}, {15'd0, W_HALT});
        for (int i = 0; i < 20; i++) begin
            load_en   = 1'b1;
            load_addr = 6'd3;
            load_data = 49'h999;
            run       = i[0];
            step();
            chk("t3_hold_halted", {63'd0, halted}, 64'd1);
            chk("t3_hold_valid", {63'd0, instr_valid}, 64'd0);
            chk("t3_hold_phase", {62'd0, phase}, 64'd1);
            chk("t3_hold_lit", {15'd0, literal}, {15'd0, W_HALT});
        end
        load_en = 1'b0;
        run     = 1'b0;

        // ---------------- load ignored while running ----------------
        do_reset(6'd0, 1'b0);
        run = 1'b1;
        step();
        run = 1'b0;
        sb_q.push_back(49'h10);
        load_en   = 1'b1;
        load_addr = 6'd3;
        load_data = 49'h777;
        step();
        step();
        load_en = 1'b0;
        do_reset(6'd3, 1'b0);
        run = 1'b1;
        step();
        run = 1'b0;
        sb_q.push_back(49'h33);
        step();
        chk("t4_mem3", {15'd0, literal}, 64'h33);

        // ---------------- simultaneous load + run ----------------
        do_reset(6'd0, 1'b0);
        load_en   = 1'b1;
        load_addr = 6'd0;
        load_data = 49'h55;
        run       = 1'b1;
        step();
        load_en = 1'b0;
        run     = 1'b0;
        chk("t5_phase0", {62'd0, phase}, 64'd0);
        sb_q.push_back(49'h55);
        step();
        chk("t5_phase1", {62'd0, phase}, 64'd1);

        // ---------------- async reset mid-slot ----------------
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_literal", {15'd0, literal}, 64'd0);
        chk("t6_phase", {62'd0, phase}, 64'd0);
        chk("t6_valid", {63'd0, instr_valid}, 64'd0);
        chk("t6_halted", {63'd0, halted}, 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        pc_drv = 6'd0;
        run    = 1'b1;
        step();
        run = 1'b0;
        chk("t6_restart_phase", {62'd0, phase}, 64'd0);
        sb_q.push_back(49'h55);
        step();
        chk("t6_retained", {15'd0, literal}, 64'h55);

        do_reset(6'd0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Program-memory and instruction-register stage that sits directly upstream of the program counter. It holds a loadable 64-entry x 49-bit program store. It captures the instruction at the current PC once per 3-cycle instruction slot and drives it as `literal` to the PC and execute logic. It owns the phase sequencing (0,1,2) that the PC's branch update is aligned to, and detects the HALT opcode.

Parameters:
ADDR_W, 6, PC/program address width; store depth is 2**ADDR_W
INSTR_W, 49, instruction width; opcode is bits [INSTR_W-1:INSTR_W-5]
HALT_OP, 5'h1F, opcode that stops fetching

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
load_en  in  1  program write strobe (honoured in IDLE only)
load_addr  in  ADDR_W  program write address
load_data  in  INSTR_W  program write data
run  in  1  level; start execution from IDLE
PC  in  ADDR_W  current program counter from PC stage
literal  out  INSTR_W  instruction register
phase  out  2  slot phase 0/1/2 (3 = never)
instr_valid  out  1  literal holds a fetched instruction this cycle
halted  out  1  HALT opcode has been fetched

Behaviour:
- Reset (async, rst_n=0): state=IDLE, literal=0, phase=0, instr_valid=0, halted=0. Program store is not cleared; contents persist across reset.
- States:
  - IDLE: each cycle with load_en=1, mem[load_addr] <= load_data. If run=1, go to RUN with phase=0 on the next cycle.
  - RUN: phase counts 0->1->2->0 every clk.
    - At the edge ending a phase-0 cycle: literal <= mem[PC] and instr_valid <= 1.
    - literal is held through phases 1 and 2. The PC stage samples it and updates PC at the end of phase 2, so the new PC is stable for the next phase-0 capture.
    - instr_valid=1 exactly during phase 1 and phase 2 cycles (from the first capture onward); 0 in phase 0.
  - HALTED: entered at the edge where the captured opcode == HALT_OP. halted=1, literal holds the HALT word, instr_valid=0, phase frozen at 1. Terminal until rst_n. run and load_en are ignored.
- Outside RUN, literal=0, which is opcode 0 (non-branch).
- load_en in RUN or HALTED: ignored; the store is unchanged.
- load_en and run both high in IDLE: the write completes. The first capture happens one cycle later, so the written word is visible if load_addr==PC.
- run deasserted in RUN: no effect. RUN is only left via HALT or reset.
- PC wrap: any PC value 0..2**ADDR_W-1 is a valid address; there is no out-of-range case.
- Reset mid-slot: outputs return to reset values immediately. On restart, phase begins at 0.
- Read path: synchronous capture into literal at phase 0; there is no combinational path from PC to literal.
- Latency: literal reflects mem[PC] one clock after the phase-0 cycle.

Test Plan:
- Load/start/capture: reset, load mem[0]=49'h0_0000_0000_0AA and mem[1]=49'h0_0000_0000_0BB, run=1 with PC=0. Required:
  - phase sequence 0,1,2,0.
  - literal=...0AA with instr_valid=1 in phases 1-2.
  - after PC is driven to 1, the next slot gives literal=...0BB.
- Branch alignment: mem[0]={5'h12,...,6'd5} (BRA 5), mem[5]=0x123, PC stage model connected. Required: next slot captures mem[5]; literal=0x123 exactly 3 cycles after the BRA capture.
- HALT: mem[2]={5'h1F,44'h0}, execute from 0. Required:
  - halted=1 one cycle after the phase-0 capture at PC=2.
  - instr_valid=0, phase stays 1, literal stays the HALT word for 20 further cycles.
  - load_en and run are ignored during this time.
- Load ignored while running: in RUN, load_en=1, load_addr=3, data=0x777. Required: after reset and a readback run, mem[3] is unchanged.
- Simultaneous load+run: in IDLE, load_en=1, addr=0, data=0x55, run=1 in the same cycle, PC=0. Required: the first captured literal=0x55.
- Async reset mid-slot: assert rst_n=0 during phase 1 between clock edges. Required:
  - literal=0, phase=0, instr_valid=0, halted=0 immediately, without waiting for a clock edge.
  - the program store retains the value written earlier.
